// File: rtl/writeback_arbiter.sv
// writeback_arbiter: per-port result FIFOs drained round-robin into the single regbank write port, plus jump redirect.
// Optional WRITEBACK_BYPASS_EN lets an accepted input skip empty FIFOs straight into the output registers.
module writeback_arbiter #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 7,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [AWIDTH-1:0] in0_rd,
    input  logic [DWIDTH-1:0] in0_data,
    input  logic              in0_jump,
    input  logic [31:0]       in0_jump_addr,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [AWIDTH-1:0] in1_rd,
    input  logic [DWIDTH-1:0] in1_data,
    output logic              write_valid,
    output logic [AWIDTH-1:0] write_address,
    output logic [DWIDTH-1:0] write_data,
    output logic              jump,
    output logic [31:0]       jump_addr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AWIDTH-1:0] mem_rd   [2][DEPTH];
    logic [DWIDTH-1:0] mem_data [2][DEPTH];
    logic [PW-1:0]     wptr  [2];
    logic [PW-1:0]     rptr  [2];
    logic [CW-1:0]     count [2];
    logic [AWIDTH-1:0] in_rd   [2];
    logic [DWIDTH-1:0] in_data [2];
    logic [1:0]        ne, acc, push, pop;
    logic              rr, byp, bsel, load;
    logic [AWIDTH-1:0] sel_rd;
    logic [DWIDTH-1:0] sel_data;

    assign in_rd[0]   = in0_rd;
    assign in_rd[1]   = in1_rd;
    assign in_data[0] = in0_data;
    assign in_data[1] = in1_data;
    // Ready depends only on reset and registered counts, never on valid.
    assign in0_ready  = !reset && count[0] != FULL;
    assign in1_ready  = !reset && count[1] != FULL;
    assign acc        = {in1_valid && in1_ready, in0_valid && in0_ready};
    assign ne         = {count[1] != '0, count[0] != '0};

    always_comb begin
`ifdef WRITEBACK_BYPASS_EN
        byp  = ne == 2'b00 && acc != 2'b00;
        bsel = &acc ? rr : acc[1];
`else
        byp  = 1'b0;
        bsel = 1'b0;
`endif
        pop[0]   = ne[0] && (!ne[1] || !rr);
        pop[1]   = ne[1] && (!ne[0] || rr);
        push[0]  = acc[0] && !(byp && !bsel);
        push[1]  = acc[1] && !(byp && bsel);
        load     = byp || |pop;
        sel_rd   = byp ? in_rd[bsel] : mem_rd[pop[1]][rptr[pop[1]]];
        sel_data = byp ? in_data[bsel] : mem_data[pop[1]][rptr[pop[1]]];
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++)
            if (push[p]) begin
                mem_rd[p][wptr[p]]   <= in_rd[p];
                mem_data[p][wptr[p]] <= in_data[p];
            end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                wptr[p]  <= '0;
                rptr[p]  <= '0;
                count[p] <= '0;
            end
            rr            <= 1'b0;
            write_valid   <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            jump          <= 1'b0;
            jump_addr     <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push[p]) wptr[p] <= wptr[p] + PW'(1);
                if (pop[p]) rptr[p] <= rptr[p] + PW'(1);
                count[p] <= count[p] + CW'(push[p]) - CW'(pop[p]);
            end
            if (&ne || (byp && &acc)) rr <= !rr;
            // Physical register 0 still consumes its slot but never strobes a write.
            write_valid <= load && sel_rd != '0;
            if (load) begin
                write_address <= sel_rd;
                write_data    <= sel_data;
            end
            jump <= acc[0] && in0_jump;
            if (acc[0] && in0_jump) jump_addr <= in0_jump_addr;
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed stimulus against a queue-based model of the writeback arbiter.
module tb_writeback_arbiter;
    localparam int DW = 32, AW = 7, DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0, reset = 1'b1;
    logic          in0_valid = 1'b0, in0_jump = 1'b0, in1_valid = 1'b0;
    logic [AW-1:0] in0_rd = '0, in1_rd = '0;
    logic [DW-1:0] in0_data = '0, in1_data = '0;
    logic [31:0]   in0_jump_addr = '0;
    logic          in0_ready, in1_ready, write_valid, jump;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_data;
    logic [31:0]   jump_addr;

    always #5 clk = ~clk;

    writeback_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_rd(in0_rd), .in0_data(in0_data),
        .in0_jump(in0_jump), .in0_jump_addr(in0_jump_addr),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_rd(in1_rd), .in1_data(in1_data),
        .write_valid(write_valid), .write_address(write_address), .write_data(write_data),
        .jump(jump), .jump_addr(jump_addr)
    );

    ent_t          q0[$], q1[$];
    bit            rr;
    logic          m_wv, m_j;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    logic [31:0]   m_ja;
    logic [AW-1:0] log_a[$];
    logic [DW-1:0] log_d[$];
    int            vecs = 0, errs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        rr = 0; m_wv = 0; m_wa = '0; m_wd = '0; m_j = 0; m_ja = '0;
    endtask

    // One clock: drive inputs, check ready, advance the model over the edge, compare all outputs.
    task automatic cycle(input logic v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                         input logic j0, input logic [31:0] ja0,
                         input logic v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                         output logic a0, output logic a1);
        ent_t e, e0, e1;
        bit got, sel;
        int n0, n1;
        in0_valid = v0; in0_rd = r0; in0_data = d0; in0_jump = j0; in0_jump_addr = ja0;
        in1_valid = v1; in1_rd = r1; in1_data = d1;
        #1;
        chk("in0_ready", in0_ready, q0.size() < DEPTH);
        chk("in1_ready", in1_ready, q1.size() < DEPTH);
        a0 = v0 && q0.size() < DEPTH;
        a1 = v1 && q1.size() < DEPTH;
        e0 = {r0, d0};
        e1 = {r1, d1};
        e = '0;
        got = 0;
        @(posedge clk);
        n0 = q0.size();
        n1 = q1.size();
`ifdef WRITEBACK_BYPASS_EN
        if (n0 == 0 && n1 == 0 && (a0 || a1)) begin
            sel = (a0 && a1) ? rr : a1;
            e = sel ? e1 : e0;
            got = 1;
            if (a0 && a1) begin
                rr = !rr;
                if (sel) q0.push_back(e0);
                else q1.push_back(e1);
            end
        end else
`endif
        begin
            sel = 0;
            if (n0 > 0 && n1 > 0) begin
                if (rr) e = q1.pop_front();
                else e = q0.pop_front();
                rr = !rr;
                got = 1;
            end else if (n0 > 0) begin
                e = q0.pop_front();
                got = 1;
            end else if (n1 > 0) begin
                e = q1.pop_front();
                got = 1;
            end
            if (a0) q0.push_back(e0);
            if (a1) q1.push_back(e1);
        end
        m_wv = got && e.rd != 0;
        if (got) begin
            m_wa = e.rd;
            m_wd = e.d;
        end
        m_j = a0 && j0;
        if (m_j) m_ja = ja0;
        #1;
        chk("write_valid", write_valid, m_wv);
        chk("write_address", write_address, m_wa);
        chk("write_data", write_data, m_wd);
        chk("jump", jump, m_j);
        chk("jump_addr", jump_addr, m_ja);
        if (write_valid) begin
            log_a.push_back(write_address);
            log_d.push_back(write_data);
        end
    endtask

    task automatic idle(input int n);
        logic a0, a1;
        for (int k = 0; k < n; k++) cycle(0, '0, '0, 0, '0, 0, '0, '0, a0, a1);
    endtask

    task automatic do_reset();
        reset = 1;
        in0_valid = 1; in0_rd = 7'd9; in0_data = 32'h99;
        in1_valid = 0;
        #2;
        chk("rst_write_valid", write_valid, 0);
        chk("rst_write_address", write_address, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_jump", jump, 0);
        chk("rst_jump_addr", jump_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in0_ready", in0_ready, 0);
        chk("rst_in1_ready", in1_ready, 0);
        chk("rst_hold_write_valid", write_valid, 0);
        reset = 0;
        model_reset();
        #1;
        chk("post_rst_in0_ready", in0_ready, 1);
        chk("post_rst_in1_ready", in1_ready, 1);
    endtask

    task automatic check_order(input string nm, input int lo, input int n);
        int j = 0;
        foreach (log_a[k])
            if (log_a[k] >= AW'(lo) && log_a[k] < AW'(lo + n)) begin
                chk(nm, log_a[k], lo + j);
                j++;
            end
        chk({nm, "_count"}, j, n);
    endtask

    initial begin
        logic a0, a1;
        int i0, i1, guard;
        bit saw_full;
        model_reset();
        do_reset();
        cycle(1, 7'd9, 32'h99, 0, '0, 0, '0, '0, a0, a1);
        idle(3);
        chk("first_entry_written", log_a.size(), 1);
        if (log_a.size() == 1) chk("first_entry_addr", log_a[0], 9);

        // single write
        cycle(1, 7'd5, 32'hDEADBEEF, 0, '0, 0, '0, '0, a0, a1);
`ifndef WRITEBACK_BYPASS_EN
        chk("single_not_yet", write_valid, 0);
        idle(1);
`endif
        chk("single_wv", write_valid, 1);
        chk("single_addr", write_address, 5);
        chk("single_data", write_data, 32'hDEADBEEF);
        idle(1);
        chk("single_one_cycle", write_valid, 0);
        chk("single_addr_hold", write_address, 5);

        // rd 0 suppressed, following entry written
        log_a.delete(); log_d.delete();
        cycle(1, 7'd0, 32'h1234, 0, '0, 0, '0, '0, a0, a1);
        cycle(1, 7'd3, 32'h33, 0, '0, 0, '0, '0, a0, a1);
        idle(3);
        chk("rd0_write_count", log_a.size(), 1);
        if (log_a.size() == 1) chk("rd0_next_addr", log_a[0], 3);

        // jump
        log_a.delete(); log_d.delete();
        cycle(1, 7'd1, 32'h2C, 1, 32'h100, 0, '0, '0, a0, a1);
        chk("jump_pulse", jump, 1);
        chk("jump_target", jump_addr, 32'h100);
        idle(1);
        chk("jump_one_cycle", jump, 0);
        chk("jump_addr_hold", jump_addr, 32'h100);
        idle(2);
        chk("jump_link_count", log_a.size(), 1);
        if (log_a.size() == 1) begin
            chk("jump_link_addr", log_a[0], 1);
            chk("jump_link_data", log_d[0], 32'h2C);
        end

        // mid-operation reset drops buffered entries
        for (int k = 0; k < 3; k++) cycle(1, AW'(10 + k), 32'(k), 0, '0, 1, AW'(30 + k), 32'(k), a0, a1);
        log_a.delete(); log_d.delete();
        do_reset();
        in0_valid = 0;
        idle(4);
        chk("reset_drops_entries", log_a.size(), 0);

        // contention
        log_a.delete(); log_d.delete();
        i0 = 0; i1 = 0; guard = 0;
        while ((i0 < 8 || i1 < 8) && guard < 200) begin
            cycle(i0 < 8, AW'(i0 + 1), 32'(100 + i0), 0, '0, i1 < 8, AW'(i1 + 65), 32'(200 + i1), a0, a1);
            if (a0) i0++;
            if (a1) i1++;
            guard++;
        end
        chk("cont_no_timeout", guard < 200, 1);
        idle(12);
        chk("cont_total", log_a.size(), 16);
`ifndef WRITEBACK_BYPASS_EN
        if (log_a.size() == 16)
            for (int k = 0; k < 16; k++)
                chk("cont_alternate", log_a[k], (k % 2) ? 65 + k / 2 : 1 + k / 2);
`endif
        check_order("cont_port0_order", 1, 8);
        check_order("cont_port1_order", 65, 8);

        // backpressure on port 1 while port 0 keeps arbitration alternating
        do_reset();
        in0_valid = 0;
        log_a.delete(); log_d.delete();
        i0 = 0; i1 = 0; guard = 0; saw_full = 0;
        while ((i0 < 10 || i1 < 10) && guard < 200) begin
            cycle(i0 < 10, AW'(40 + i0), 32'(i0), 0, '0, i1 < 10, AW'(20 + i1), 32'(i1), a0, a1);
            if (a0) i0++;
            if (a1) i1++;
            if (!in1_ready) saw_full = 1;
            guard++;
        end
        chk("bp_no_timeout", guard < 200, 1);
        chk("bp_in1_ready_dropped", saw_full, 1);
        idle(24);
        chk("bp_total", log_a.size(), 20);
        check_order("bp_port0_order", 40, 10);
        check_order("bp_port1_order", 20, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
